// File: rtl/doorlock_pkg.sv
// Shared state/status encodings and the reset password for the door-lock controller.
package doorlock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OPEN = 2'b01,
        ST_FAIL = 2'b10,
        ST_LOCK = 2'b11
    } state_e;

    localparam logic [1:0] SEG_IDLE = 2'b00;
    localparam logic [1:0] SEG_OPEN = 2'b01;
    localparam logic [1:0] SEG_ERR  = 2'b10;
    localparam logic [1:0] SEG_LOCK = 2'b11;

    localparam logic [3:0] DEFAULT_PW = 4'b1101;

    function automatic logic [1:0] seg_of(input state_e s);
        logic [1:0] seg;
        case (s)
            ST_OPEN: seg = SEG_OPEN;
            ST_FAIL: seg = SEG_ERR;
            ST_LOCK: seg = SEG_LOCK;
            default: seg = SEG_IDLE;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/doorlock_timer.sv
// Loadable down-counter; holds at zero and flags it, load has priority over counting.
module doorlock_timer #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/doorlock_ctrl.sv
// Door-lock sequencer: keypad check/set, timed open/fail hold, failed-attempt counting.
// Timed lockout after MAX_TRIES wrong codes exists only when DOORLOCK_LOCKOUT_EN is defined.
module doorlock_ctrl #(
    parameter int unsigned     PW_W        = 4,
    parameter logic [PW_W-1:0] DEFAULT_PW  = doorlock_pkg::DEFAULT_PW,
    parameter int unsigned     MAX_TRIES   = 3,
    parameter int unsigned     OPEN_CYCLES = 8,
    parameter int unsigned     FAIL_CYCLES = 4,
    parameter int unsigned     LOCK_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            chk_req,
    input  logic            set_req,
    input  logic [PW_W-1:0] ps_num,
    output logic            door_open,
    output logic [1:0]      state_out,
    output logic [1:0]      seg_out,
    output logic [1:0]      tries_left
);

    import doorlock_pkg::*;

    localparam int unsigned MAX_A   = (OPEN_CYCLES > FAIL_CYCLES) ? OPEN_CYCLES : FAIL_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_A > LOCK_CYCLES) ? MAX_A : LOCK_CYCLES;
    localparam int unsigned TW      = $clog2(MAX_CYC) + 1;

    localparam logic [TW-1:0] OPEN_LD   = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] FAIL_LD   = TW'(FAIL_CYCLES - 1);
    localparam logic [1:0]    TRIES_MAX = 2'(MAX_TRIES);

    state_e          state_q, state_d;
    logic [1:0]      tries_q, tries_d;
    logic [PW_W-1:0] pw_q, pw_d;
    logic            door_q;
    logic [1:0]      seg_q;
    logic            tmr_load, tmr_zero;
    logic [TW-1:0]   tmr_val;

    always_comb begin
        state_d  = state_q;
        tries_d  = tries_q;
        pw_d     = pw_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (chk_req) begin
                    tmr_load = 1'b1;
                    if (ps_num == pw_q) begin
                        state_d = ST_OPEN;
                        tmr_val = OPEN_LD;
                        tries_d = TRIES_MAX;
`ifdef DOORLOCK_LOCKOUT_EN
                    end else if (tries_q == 2'd1) begin
                        state_d = ST_LOCK;
                        tmr_val = TW'(LOCK_CYCLES - 1);
                        tries_d = '0;
                    end else begin
                        state_d = ST_FAIL;
                        tmr_val = FAIL_LD;
                        tries_d = tries_q - 2'd1;
                    end
`else
                    end else begin
                        state_d = ST_FAIL;
                        tmr_val = FAIL_LD;
                    end
`endif
                end
            end
            // set_req restarts the open window even on its final cycle
            ST_OPEN: begin
                if (set_req) begin
                    pw_d     = ps_num;
                    tmr_load = 1'b1;
                    tmr_val  = OPEN_LD;
                end else if (tmr_zero) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FAIL: begin
                if (tmr_zero) state_d = ST_IDLE;
            end
            ST_LOCK: begin
                if (tmr_zero) begin
                    state_d = ST_IDLE;
                    tries_d = TRIES_MAX;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tries_q <= TRIES_MAX;
            pw_q    <= DEFAULT_PW;
            door_q  <= 1'b0;
            seg_q   <= SEG_IDLE;
        end else begin
            state_q <= state_d;
            tries_q <= tries_d;
            pw_q    <= pw_d;
            door_q  <= (state_d == ST_OPEN);
            seg_q   <= seg_of(state_d);
        end
    end

    doorlock_timer #(
        .W (TW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    assign state_out  = state_q;
    assign door_open  = door_q;
    assign seg_out    = seg_q;
    assign tries_left = tries_q;

endmodule

// File: tb/tb_doorlock_ctrl.sv
// Scoreboard bench for doorlock_ctrl: a cycle model predicts outputs, a monitor compares them.
module tb_doorlock_ctrl;

    localparam int PW_W        = 4;
    localparam int MAX_TRIES   = 3;
    localparam int OPEN_CYCLES = 8;
    localparam int FAIL_CYCLES = 4;
    localparam int LOCK_CYCLES = 16;
    localparam logic [3:0] RESET_PW = 4'b1101;
`ifdef DOORLOCK_LOCKOUT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            chk_req = 1'b0;
    logic            set_req = 1'b0;
    logic [PW_W-1:0] ps_num = '0;
    logic            door_open;
    logic [1:0]      state_out, seg_out, tries_left;

    always #5 clk = ~clk;

    doorlock_ctrl #(
        .PW_W        (PW_W),
        .DEFAULT_PW  (RESET_PW),
        .MAX_TRIES   (MAX_TRIES),
        .OPEN_CYCLES (OPEN_CYCLES),
        .FAIL_CYCLES (FAIL_CYCLES),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .chk_req    (chk_req),
        .set_req    (set_req),
        .ps_num     (ps_num),
        .door_open  (door_open),
        .state_out  (state_out),
        .seg_out    (seg_out),
        .tries_left (tries_left)
    );

    typedef struct packed {
        logic [1:0] st;
        logic       door;
        logic [1:0] seg;
        logic [1:0] tries;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference: mode plus number of cycles left in that mode (not a down-counter to zero).
    typedef enum int {M_IDLE, M_OPEN, M_ERR, M_LOCK} mmode_e;
    mmode_e    m_mode  = M_IDLE;
    int        m_left  = 0;
    int        m_tries = MAX_TRIES;
    logic [3:0] m_pw   = RESET_PW;

    task automatic model_edge(input logic r, input logic c, input logic s, input logic [3:0] n);
        if (r) begin
            m_mode = M_IDLE; m_left = 0; m_tries = MAX_TRIES; m_pw = RESET_PW;
        end else begin
            case (m_mode)
                M_IDLE: if (c) begin
                    if (n == m_pw) begin
                        m_mode = M_OPEN; m_left = OPEN_CYCLES; m_tries = MAX_TRIES;
                    end else if (LOCK_EN && m_tries == 1) begin
                        m_mode = M_LOCK; m_left = LOCK_CYCLES; m_tries = 0;
                    end else begin
                        m_mode = M_ERR; m_left = FAIL_CYCLES;
                        if (LOCK_EN) m_tries = m_tries - 1;
                    end
                end
                M_OPEN: begin
                    if (s) begin
                        m_pw = n; m_left = OPEN_CYCLES;
                    end else begin
                        m_left = m_left - 1;
                        if (m_left == 0) m_mode = M_IDLE;
                    end
                end
                M_ERR: begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_mode = M_IDLE;
                end
                default: begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_mode = M_IDLE; m_tries = MAX_TRIES;
                    end
                end
            endcase
        end
    endtask

    function automatic exp_t observe();
        exp_t e;
        case (m_mode)
            M_OPEN:  e.st = 2'b01;
            M_ERR:   e.st = 2'b10;
            M_LOCK:  e.st = 2'b11;
            default: e.st = 2'b00;
        endcase
        e.door  = (m_mode == M_OPEN);
        e.seg   = e.st;
        e.tries = 2'(m_tries);
        return e;
    endfunction

    task automatic step(input logic r, input logic c, input logic s, input logic [3:0] n);
        @(negedge clk);
        rst = r; chk_req = c; set_req = s; ps_num = n;
        model_edge(r, c, s, n);
        exp_q.push_back(observe());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'($urandom_range(0, 15)));
    endtask

    initial begin : monitor
        exp_t e, got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {state_out, door_open, seg_out, tries_left};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t got st=%b door=%b seg=%b tries=%0d expected st=%b door=%b seg=%b tries=%0d",
                             $time, got.st, got.door, got.seg, got.tries, e.st, e.door, e.seg, e.tries);
                end
            end
        end
    end

    initial begin : stimulus
        step(1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b1, 1'b1, 4'h0);
        // correct code, full open window
        step(1'b0, 1'b1, 1'b0, 4'b1101);
        idle(10);
        // password change in OPEN, old code now wrong, new code opens
        step(1'b0, 1'b1, 1'b0, 4'b1101);
        step(1'b0, 1'b0, 1'b1, 4'b0110);
        idle(10);
        step(1'b0, 1'b1, 1'b0, 4'b1101);
        idle(5);
        step(1'b0, 1'b1, 1'b0, 4'b0110);
        idle(10);
        // three wrong codes, then correct code during lockout (ignored)
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 1'b0, 4'b0000);
            idle(5);
        end
        step(1'b0, 1'b1, 1'b0, 4'b0110);
        idle(18);
        // simultaneous requests in IDLE then in OPEN
        step(1'b0, 1'b1, 1'b1, 4'b0110);
        idle(3);
        step(1'b0, 1'b1, 1'b1, 4'b1001);
        idle(10);
        step(1'b0, 1'b1, 1'b0, 4'b1001);
        idle(3);
        // reset mid-OPEN after a password change
        step(1'b0, 1'b0, 1'b1, 4'b0011);
        idle(2);
        step(1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b1, 1'b0, 4'b0011);
        idle(5);
        // reset mid-LOCKOUT
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 1'b0, 4'b0000);
            idle(5);
        end
        step(1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b1, 1'b0, 4'b1101);
        idle(10);
        // five consecutive wrong codes
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, 1'b0, 4'b0101);
            idle(5);
        end
        idle(16);
        // random traffic, matches biased toward the modelled password
        for (int i = 0; i < 2000; i++) begin
            logic [3:0] n;
            n = ($urandom_range(0, 1) == 0) ? m_pw : 4'($urandom_range(0, 15));
            step(($urandom_range(0, 249) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) == 0), n);
        end
        repeat (4) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
